// File: rtl/vdp_super_palette_if.sv
// Video lookup and CPU pointer/data port of the super-res palette, bundled for one port.
interface vdp_super_palette_if;
   logic [7:0] PALETTE_ADDR2;
   logic [7:0] PALETTE_DATA_R2_OUT;
   logic [7:0] PALETTE_DATA_G2_OUT;
   logic [7:0] PALETTE_DATA_B2_OUT;
   logic       ptr_wr;
   logic [7:0] ptr_data;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       init_busy;
   logic [7:0] pointer;

   modport master (
      output PALETTE_ADDR2, ptr_wr, ptr_data, wr_en, wr_data, rd_en,
      input  PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT,
      input  rd_data, rd_valid, init_busy, pointer
   );

   modport slave (
      input  PALETTE_ADDR2, ptr_wr, ptr_data, wr_en, wr_data, rd_en,
      output PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT,
      output rd_data, rd_valid, init_busy, pointer
   );
endinterface

// File: rtl/vdp_super_palette.sv
// 256x24 RGB palette: registered video lookup and CPU readback (1 cycle), R->G->B byte sequencer.
// No backpressure; CPU strobes are ignored while the RGB332 default fill runs after reset.
module vdp_super_palette #(
   parameter bit INIT_DEFAULT = 1'b1,
   parameter int ENTRIES      = 256
) (
   input  logic               clk,
   input  logic               reset_n,
   vdp_super_palette_if.slave bus
);
   typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_B = 2'd2} phase_t;

   phase_t      r_phase;
   phase_t      w_phase_nxt;
   logic [7:0]  r_ptr;
   logic [7:0]  w_ptr_nxt;
   logic [7:0]  r_stage_r;
   logic [7:0]  r_stage_g;
   logic [7:0]  r_init_cnt;
   logic        r_init_busy;
   logic [23:0] r_vid;
   logic [7:0]  r_rd_data;
   logic        r_rd_valid;
   logic [23:0] r_ram [ENTRIES];

   logic        w_commit;
   logic        w_stage_r_ld;
   logic        w_stage_g_ld;
   logic        w_ptr_load;
   logic        w_rd_fire;
   logic [23:0] w_init_rgb;
   logic [23:0] w_cpu_word;
   logic [7:0]  w_rd_byte;
   logic        w_ram_we;
   logic [7:0]  w_ram_waddr;
   logic [23:0] w_ram_wdata;

   // Sequencer: ptr_wr beats wr_en, wr_en beats rd_en; reads walk phase/pointer like writes.
   always_comb begin
      w_phase_nxt  = r_phase;
      w_ptr_nxt    = r_ptr;
      w_commit     = 1'b0;
      w_stage_r_ld = 1'b0;
      w_stage_g_ld = 1'b0;
      w_ptr_load   = 1'b0;
      w_rd_fire    = 1'b0;
      if (!r_init_busy) begin
         if (bus.ptr_wr) begin
            w_ptr_load  = 1'b1;
            w_ptr_nxt   = bus.ptr_data;
            w_phase_nxt = PH_R;
         end else if (bus.wr_en || bus.rd_en) begin
            w_rd_fire = !bus.wr_en;
            case (r_phase)
               PH_R: begin
                  w_stage_r_ld = bus.wr_en;
                  w_phase_nxt  = PH_G;
               end
               PH_G: begin
                  w_stage_g_ld = bus.wr_en;
                  w_phase_nxt  = PH_B;
               end
               default: begin
                  w_commit    = bus.wr_en;
                  w_phase_nxt = PH_R;
                  w_ptr_nxt   = r_ptr + 8'd1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= PH_R;
         r_ptr   <= 8'd0;
      end else begin
         r_phase <= w_phase_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stage_r <= 8'd0;
         r_stage_g <= 8'd0;
      end else if (w_ptr_load) begin
         r_stage_r <= 8'd0;
         r_stage_g <= 8'd0;
      end else begin
         if (w_stage_r_ld) r_stage_r <= bus.wr_data;
         if (w_stage_g_ld) r_stage_g <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_init_busy <= INIT_DEFAULT;
         r_init_cnt  <= 8'd0;
      end else if (r_init_busy) begin
         r_init_cnt <= r_init_cnt + 8'd1;
         if (r_init_cnt == 8'(ENTRIES - 1)) r_init_busy <= 1'b0;
      end
   end

   assign w_init_rgb = {r_init_cnt[7:5], r_init_cnt[7:5], r_init_cnt[7:6],
                        r_init_cnt[4:2], r_init_cnt[4:2], r_init_cnt[4:3],
                        r_init_cnt[1:0], r_init_cnt[1:0], r_init_cnt[1:0], r_init_cnt[1:0]};

   // Whole entry lands in one edge, so video never sees a half-written colour.
   assign w_ram_we    = r_init_busy || w_commit;
   assign w_ram_waddr = r_init_busy ? r_init_cnt : r_ptr;
   assign w_ram_wdata = r_init_busy ? w_init_rgb : {r_stage_r, r_stage_g, bus.wr_data};

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_ram_waddr] <= w_ram_wdata;
   end

   assign w_cpu_word = r_ram[r_ptr];

   always_comb begin
      w_rd_byte = w_cpu_word[7:0];
      case (r_phase)
         PH_R:    w_rd_byte = w_cpu_word[23:16];
         PH_G:    w_rd_byte = w_cpu_word[15:8];
         default: w_rd_byte = w_cpu_word[7:0];
      endcase
   end

   // Read before write: a same-edge commit to the looked-up entry shows up on the next lookup.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vid      <= 24'd0;
         r_rd_data  <= 8'd0;
         r_rd_valid <= 1'b0;
      end else begin
         r_vid      <= r_ram[bus.PALETTE_ADDR2];
         r_rd_valid <= w_rd_fire;
         if (w_rd_fire) r_rd_data <= w_rd_byte;
      end
   end

   assign bus.PALETTE_DATA_R2_OUT = r_vid[23:16];
   assign bus.PALETTE_DATA_G2_OUT = r_vid[15:8];
   assign bus.PALETTE_DATA_B2_OUT = r_vid[7:0];
   assign bus.rd_data             = r_rd_data;
   assign bus.rd_valid            = r_rd_valid;
   assign bus.init_busy           = r_init_busy;
   assign bus.pointer             = r_ptr;
endmodule
